// File: rtl/control_unit.sv
// control_unit: four-state sequencer for a simple processor (mv, mvi, add, sub, nop).
module control_unit (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Run,
  input  logic [15:0] DIN,
  output logic        IRin,
  output logic [0:7]  Rout,
  output logic        Gout,
  output logic        DINout,
  output logic [0:7]  Rin,
  output logic        Ain,
  output logic        Gin,
  output logic        AddSub,
  output logic        Done
);
  typedef enum logic [1:0] {T0, T1, T2, T3} state_t;
  state_t state_q, state_d;
  logic [8:0] ir_q;
  logic [2:0] op, x, y;
  logic unused_din;
  assign unused_din = ^DIN[6:0];
  assign op = ir_q[8:6];
  assign x  = ir_q[5:3];
  assign y  = ir_q[2:0];
  // Index 0 is the MSB of a [0:7] vector, so shifting right walks toward R7.
  function automatic logic [0:7] dec(input logic [2:0] s);
    return 8'b1000_0000 >> s;
  endfunction
  always_ff @(posedge Clock or negedge Resetn)
    if (!Resetn) begin
      state_q <= T0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == T0 && Run) ir_q <= DIN[15:7];
    end
  always_comb begin
    state_d = state_q;
    IRin    = 1'b0;
    Rout    = '0;
    Gout    = 1'b0;
    DINout  = 1'b0;
    Rin     = '0;
    Ain     = 1'b0;
    Gin     = 1'b0;
    AddSub  = 1'b0;
    Done    = 1'b0;
    case (state_q)
      T0: begin
        IRin    = Run;
        state_d = Run ? T1 : T0;
      end
      T1: case (op)
        3'b000: begin
          Rout    = dec(y);
          Rin     = dec(x);
          Done    = 1'b1;
          state_d = T0;
        end
        3'b001: begin
          DINout  = 1'b1;
          Rin     = dec(x);
          Done    = 1'b1;
          state_d = T0;
        end
        3'b010, 3'b011: begin
          Rout    = dec(x);
          Ain     = 1'b1;
          state_d = T2;
        end
        default: begin
          Done    = 1'b1;
          state_d = T0;
        end
      endcase
      T2: begin
        Rout    = dec(y);
        Gin     = 1'b1;
        AddSub  = ir_q[6];
        state_d = T3;
      end
      default: begin
        Gout    = 1'b1;
        Rin     = dec(x);
        Done    = 1'b1;
        state_d = T0;
      end
    endcase
    // Outputs are held low for the whole reset interval, not just after the edge.
    if (!Resetn) begin
      IRin   = 1'b0;
      Rout   = '0;
      Gout   = 1'b0;
      DINout = 1'b0;
      Rin    = '0;
      Ain    = 1'b0;
      Gin    = 1'b0;
      AddSub = 1'b0;
      Done   = 1'b0;
    end
  end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed vector bench for control_unit.
module tb_control_unit;
  logic        Clock, Resetn, Run;
  logic [15:0] DIN;
  logic        IRin, Gout, DINout, Ain, Gin, AddSub, Done;
  logic [0:7]  Rout, Rin;
  int checks = 0;
  int errors = 0;

  control_unit dut (
    .Clock(Clock), .Resetn(Resetn), .Run(Run), .DIN(DIN),
    .IRin(IRin), .Rout(Rout), .Gout(Gout), .DINout(DINout), .Rin(Rin),
    .Ain(Ain), .Gin(Gin), .AddSub(AddSub), .Done(Done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic        run;
    logic [8:0]  ir;
    logic [22:0] exp;
    string       name;
  } vec_t;

  vec_t v[22];

  // {IRin, Rout[0:7], Gout, DINout, Rin[0:7], Ain, Gin, AddSub, Done}
  function automatic logic [22:0] o(input logic irin, input logic [7:0] rout, input logic gout,
                                    input logic dinout, input logic [7:0] rin, input logic ain,
                                    input logic gin, input logic as, input logic done);
    return {irin, rout, gout, dinout, rin, ain, gin, as, done};
  endfunction

  function automatic vec_t mk(input logic run, input logic [8:0] ir, input logic [22:0] exp,
                              input string name);
    vec_t r;
    r.run = run; r.ir = ir; r.exp = exp; r.name = name;
    return r;
  endfunction

  task automatic chk(input string name, input logic [22:0] exp);
    logic [22:0] got;
    got = {IRin, Rout, Gout, DINout, Rin, Ain, Gin, AddSub, Done};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge Clock) begin
    #2;
    checks++;
    assert ($countones({Rout, Gout, DINout}) <= 1 && $countones(Rin) <= 1)
    else begin
      errors++;
      $display("FAIL bus_onehot Rout=%b Gout=%b DINout=%b Rin=%b", Rout, Gout, DINout, Rin);
    end
  end

  initial begin
    v[0]  = mk(1, 9'b001_000_000, o(1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0), "mvi_t0");
    v[1]  = mk(0, 9'b111_111_111, o(0, 8'h00, 0, 1, 8'h80, 0, 0, 0, 1), "mvi_t1");
    v[2]  = mk(1, 9'b000_001_000, o(1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0), "mv_t0");
    v[3]  = mk(0, 9'b000_000_000, o(0, 8'h80, 0, 0, 8'h40, 0, 0, 0, 1), "mv_t1");
    v[4]  = mk(1, 9'b011_010_101, o(1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0), "sub_t0");
    v[5]  = mk(1, 9'b000_000_000, o(0, 8'h20, 0, 0, 8'h00, 1, 0, 0, 0), "sub_t1");
    v[6]  = mk(1, 9'b000_000_000, o(0, 8'h04, 0, 0, 8'h00, 0, 1, 1, 0), "sub_t2");
    v[7]  = mk(1, 9'b000_000_000, o(0, 8'h00, 1, 0, 8'h20, 0, 0, 0, 1), "sub_t3");
    v[8]  = mk(0, 9'b000_000_000, o(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0), "idle_t0");
    v[9]  = mk(1, 9'b101_110_011, o(1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0), "nop_t0");
    v[10] = mk(0, 9'b000_000_000, o(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 1), "nop_t1");
    v[11] = mk(1, 9'b000_011_011, o(1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0), "mv33_t0");
    v[12] = mk(0, 9'b000_000_000, o(0, 8'h10, 0, 0, 8'h10, 0, 0, 0, 1), "mv33_t1");
    v[13] = mk(1, 9'b010_010_010, o(1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0), "add22_t0");
    v[14] = mk(1, 9'b000_000_000, o(0, 8'h20, 0, 0, 8'h00, 1, 0, 0, 0), "add22_t1");
    v[15] = mk(1, 9'b000_000_000, o(0, 8'h20, 0, 0, 8'h00, 0, 1, 0, 0), "add22_t2");
    v[16] = mk(1, 9'b000_000_000, o(0, 8'h00, 1, 0, 8'h20, 0, 0, 0, 1), "add22_t3");
    v[17] = mk(1, 9'b010_001_011, o(1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0), "add13_t0");
    v[18] = mk(1, 9'b000_000_000, o(0, 8'h40, 0, 0, 8'h00, 1, 0, 0, 0), "add13_t1");
    v[19] = mk(1, 9'b000_000_000, o(0, 8'h10, 0, 0, 8'h00, 0, 1, 0, 0), "add13_t2");
    v[20] = mk(1, 9'b000_000_000, o(0, 8'h00, 1, 0, 8'h40, 0, 0, 0, 1), "add13_t3");
    v[21] = mk(0, 9'b000_000_000, o(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0), "end_t0");

    Resetn = 1'b0;
    Run    = 1'b1;
    DIN    = {9'b001_000_000, 7'h7f};
    #2 chk("reset_async", '0);
    @(negedge Clock);
    chk("reset_held", '0);
    Resetn = 1'b1;
    Run    = 1'b0;

    for (int i = 0; i < 22; i++) begin
      @(negedge Clock);
      Run = v[i].run;
      DIN = {v[i].ir, 7'h55};
      #1 chk(v[i].name, v[i].exp);
    end

    @(negedge Clock);
    Run = 1'b1;
    DIN = {9'b010_100_110, 7'h00};
    #1 chk("abort_t0", o(1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0));
    @(negedge Clock);
    Run = 1'b0;
    #1 chk("abort_t1", o(0, 8'h08, 0, 0, 8'h00, 1, 0, 0, 0));
    @(negedge Clock);
    #1 chk("abort_t2", o(0, 8'h02, 0, 0, 8'h00, 0, 1, 0, 0));
    #1 Resetn = 1'b0;
    #1 chk("abort_drop", '0);
    @(negedge Clock);
    #1 chk("abort_hold", '0);
    Resetn = 1'b1;
    #1 chk("abort_release", '0);
    @(negedge Clock);
    #1 chk("abort_no_t3", '0);
    Run = 1'b1;
    DIN = {9'b001_111_000, 7'h2a};
    #1 chk("post_mvi_t0", o(1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0));
    @(negedge Clock);
    Run = 1'b0;
    #1 chk("post_mvi_t1", o(0, 8'h00, 0, 1, 8'h01, 0, 0, 0, 1));
    @(negedge Clock);
    #1 chk("post_idle", '0);

    @(negedge Clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
